// File: rtl/ds1302_slavemod_if.sv
// Side-band access to the DS1302 responder: register peek and write-commit report.
// Peek is combinational; the commit report is registered and has no backpressure.
interface ds1302_slavemod_if;
    logic [5:0] iPeekAddr;
    logic [7:0] oPeekData;
    logic       oWrStrobe;
    logic [5:0] oWrAddr;
    logic [7:0] oWrData;

    modport slave  (input  iPeekAddr, output oPeekData, oWrStrobe, oWrAddr, oWrData);
    modport master (output iPeekAddr, input  oPeekData, oWrStrobe, oWrAddr, oWrData);
endinterface

// File: rtl/ds1302_slavemod.sv
// DS1302 3-wire responder: single-byte reads/writes to an 8-byte clock bank and 31-byte RAM.
// Pins reach the FSM 3 CLOCKs after they change; no backpressure, the master paces everything.
module ds1302_slavemod (
    input  logic CLOCK,
    input  logic RESET,
    input  logic RTC_NRST,
    input  logic RTC_SCLK,
    inout  wire  RTC_DATA,
    ds1302_slavemod_if.slave side
);

    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;

    state_t     state_q;
    logic [1:0] nrst_sync_q;
    logic [1:0] sclk_sync_q;
    logic [1:0] data_sync_q;
    logic       sclk_prev_q;
    logic [2:0] bitcnt_q;
    logic [2:0] fcnt_q;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic       cmd_ram_q;
    logic [4:0] cmd_addr_q;
    logic [7:0] rd_byte_q;
    logic       oe_q;
    logic       dout_q;
    logic [7:0] clk_bank_q [8];
    logic [7:0] ram_q [31];
    logic       wr_strobe_q;
    logic [5:0] wr_addr_q;
    logic [7:0] wr_data_q;

    logic nrst_s, sclk_s, data_s, sclk_rise, sclk_fall;
    assign nrst_s    = nrst_sync_q[1];
    assign sclk_s    = sclk_sync_q[1];
    assign data_s    = data_sync_q[1];
    assign sclk_rise =  sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s &  sclk_prev_q;

    function automatic logic [7:0] read_reg(input logic ram, input logic [4:0] a);
        if (ram)
            return (a != 5'd31) ? ram_q[a] : 8'h00;
        else
            return (a < 5'd8) ? clk_bank_q[a[2:0]] : 8'h00;
    endfunction

    // With WP set, only the control register itself stays writable so WP can be cleared.
    function automatic logic write_ok(input logic ram, input logic [4:0] a, input logic wp);
        logic impl;
        impl = ram ? (a != 5'd31) : (a < 5'd8);
        return impl && (!wp || (!ram && a == 5'd7));
    endfunction

    always_comb begin
        shift_d           = shift_q;
        shift_d[bitcnt_q] = data_s;
    end

    always_comb begin
        side.oPeekData = read_reg(side.iPeekAddr[5], side.iPeekAddr[4:0]);
    end

    assign side.oWrStrobe = wr_strobe_q;
    assign side.oWrAddr   = wr_addr_q;
    assign side.oWrData   = wr_data_q;
    assign RTC_DATA       = oe_q ? dout_q : 1'bz;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            nrst_sync_q <= 2'b00;
            sclk_sync_q <= 2'b00;
            data_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            bitcnt_q    <= 3'd0;
            fcnt_q      <= 3'd0;
            shift_q     <= 8'h00;
            cmd_ram_q   <= 1'b0;
            cmd_addr_q  <= 5'd0;
            rd_byte_q   <= 8'h00;
            oe_q        <= 1'b0;
            dout_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 6'h00;
            wr_data_q   <= 8'h00;
            for (int i = 0; i < 8; i++)  clk_bank_q[i] <= 8'h00;
            for (int i = 0; i < 31; i++) ram_q[i]      <= 8'h00;
        end else begin
            nrst_sync_q <= {nrst_sync_q[0], RTC_NRST};
            sclk_sync_q <= {sclk_sync_q[0], RTC_SCLK};
            data_sync_q <= {data_sync_q[0], RTC_DATA};
            sclk_prev_q <= sclk_s;
            wr_strobe_q <= 1'b0;

            if (!nrst_s) begin
                state_q  <= IDLE;
                oe_q     <= 1'b0;
                bitcnt_q <= 3'd0;
                fcnt_q   <= 3'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q  <= CMD;
                        bitcnt_q <= 3'd0;
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                cmd_ram_q  <= shift_d[6];
                                cmd_addr_q <= shift_d[5:1];
                                if (!shift_d[7]) begin
                                    state_q <= DONE;
                                end else if (!shift_d[0]) begin
                                    state_q <= WDATA;
                                end else begin
                                    state_q   <= RDATA;
                                    fcnt_q    <= 3'd0;
                                    rd_byte_q <= read_reg(shift_d[6], shift_d[5:1]);
                                end
                            end
                        end
                    end
                    WDATA: begin
                        if (sclk_rise) begin
                            shift_q  <= shift_d;
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                state_q <= DONE;
                                if (write_ok(cmd_ram_q, cmd_addr_q, clk_bank_q[7][7])) begin
                                    if (cmd_ram_q)
                                        ram_q[cmd_addr_q] <= shift_d;
                                    else
                                        clk_bank_q[cmd_addr_q[2:0]] <= shift_d;
                                    wr_strobe_q <= 1'b1;
                                    wr_addr_q   <= {cmd_ram_q, cmd_addr_q};
                                    wr_data_q   <= shift_d;
                                end
                            end
                        end
                    end
                    RDATA: begin
                        if (sclk_fall) begin
                            dout_q <= rd_byte_q[fcnt_q];
                            oe_q   <= 1'b1;
                            fcnt_q <= fcnt_q + 3'd1;
                        end
                        if (sclk_rise) begin
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                oe_q    <= 1'b0;
                                state_q <= DONE;
                            end
                        end
                    end
                    DONE: begin
                        state_q <= DONE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ds1302_slavemod.sv
// Randomized bench for ds1302_slavemod: a serial master drives transactions, a register-bank
// model predicts commits and read bytes, and monitors score them as the DUT produces them.
module tb_ds1302_slavemod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, nrst, sclk, drv_en, drv_val;
    wire  rtc_data;
    assign rtc_data = drv_en ? drv_val : 1'bz;

    ds1302_slavemod_if bus();

    ds1302_slavemod dut (
        .CLOCK    (clk),
        .RESET    (rst_n),
        .RTC_NRST (nrst),
        .RTC_SCLK (sclk),
        .RTC_DATA (rtc_data),
        .side     (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;
    logic must_float = 1'b0;
    int float_viol = 0;

    logic [7:0]  mclk [8];
    logic [7:0]  mram [31];
    logic [13:0] exp_wr_q [$];
    logic [7:0]  exp_rd_q [$];
    logic [7:0]  obs_rd_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] model_peek(input logic ram, input logic [4:0] a);
        if (ram) return (a != 5'd31) ? mram[a] : 8'h00;
        return (a < 5'd8) ? mclk[a[2:0]] : 8'h00;
    endfunction

    // Write-commit monitor: every strobe must match the oldest predicted commit.
    always @(negedge clk) begin
        if (bus.oWrStrobe) begin
            if (exp_wr_q.size() == 0) begin
                check("unexpected_strobe", {18'd0, bus.oWrAddr, bus.oWrData}, 32'hFFFF_FFFF);
            end else begin
                logic [13:0] e;
                e = exp_wr_q.pop_front();
                check("wr_addr", {26'd0, bus.oWrAddr}, {26'd0, e[13:8]});
                check("wr_data", {24'd0, bus.oWrData}, {24'd0, e[7:0]});
                check("wr_latency", cyc - last_rise, 3);
            end
        end
        if (must_float && dut.oe_q) float_viol++;
    end

    // Read monitor: pairs each byte the master captured with the predicted byte.
    always @(negedge clk) begin
        if (obs_rd_q.size() != 0) begin
            logic [7:0] o;
            o = obs_rd_q.pop_front();
            if (exp_rd_q.size() == 0)
                check("unexpected_read", {24'd0, o}, 32'hFFFF_FFFF);
            else
                check("rd_data", {24'd0, o}, {24'd0, exp_rd_q.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_tx();
        nrst = 1'b1;
        tick(4);
    endtask

    task automatic end_tx();
        tick(2);
        nrst = 1'b0;
        tick(4);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            drv_en  = 1'b1;
            drv_val = b[i];
            tick(6);
            sclk = 1'b1;
            last_rise = cyc;
            tick(6);
            sclk = 1'b0;
        end
        drv_en = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            tick(6);
            b[i] = rtc_data;
            sclk = 1'b1;
            tick(6);
            sclk = 1'b0;
        end
    endtask

    task automatic do_write(input logic [7:0] cmd, input logic [7:0] dat);
        logic       ram;
        logic [4:0] a;
        ram = cmd[6];
        a   = cmd[5:1];
        if (cmd[7] && !cmd[0] && (ram ? (a != 5'd31) : (a < 5'd8)) &&
            (!mclk[7][7] || (!ram && a == 5'd7))) begin
            if (ram) mram[a] = dat;
            else     mclk[a[2:0]] = dat;
            exp_wr_q.push_back({ram, a, dat});
        end
        must_float = 1'b1;
        float_viol = 0;
        begin_tx();
        send_bits(cmd, 8);
        send_bits(dat, 8);
        end_tx();
        must_float = 1'b0;
        check("bus_float_wr", float_viol, 0);
        bus.iPeekAddr = {ram, a};
        #1;
        check("peek_after_wr", {24'd0, bus.oPeekData}, {24'd0, model_peek(ram, a)});
    endtask

    task automatic do_read(input logic [7:0] cmd);
        logic [7:0] b;
        exp_rd_q.push_back(model_peek(cmd[6], cmd[5:1]));
        begin_tx();
        send_bits(cmd, 8);
        recv_byte(b);
        end_tx();
        obs_rd_q.push_back(b);
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog expired actual=running expected=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [7:0] r, c;
        logic [4:0] a;
        rst_n = 1'b0; nrst = 1'b0; sclk = 1'b0; drv_en = 1'b0; drv_val = 1'b0;
        bus.iPeekAddr = 6'h00;
        for (int i = 0; i < 8; i++)  mclk[i] = 8'h00;
        for (int i = 0; i < 31; i++) mram[i] = 8'h00;
        tick(3);
        check("rst_oe", {31'd0, dut.oe_q}, 0);
        check("rst_strobe", {31'd0, bus.oWrStrobe}, 0);
        check("rst_wr_addr", {26'd0, bus.oWrAddr}, 0);
        check("rst_wr_data", {24'd0, bus.oWrData}, 0);
        rst_n = 1'b1;
        tick(3);

        // Basic write then read-back of seconds.
        do_write(8'h80, 8'h59);
        do_read(8'h81);

        // Write protect blocks ordinary writes until cleared.
        do_write(8'h8E, 8'h80);
        do_write(8'h82, 8'h12);
        bus.iPeekAddr = 6'h01; #1;
        check("wp_blocked", {24'd0, bus.oPeekData}, 32'h00);
        do_write(8'h8E, 8'h00);
        do_write(8'h82, 8'h12);
        bus.iPeekAddr = 6'h01; #1;
        check("wp_cleared", {24'd0, bus.oPeekData}, 32'h12);

        // RAM address 5 is distinct from clock address 5.
        do_write(8'hCA, 8'hA5);
        do_read(8'hCB);
        bus.iPeekAddr = 6'h25; #1;
        check("ram5_peek", {24'd0, bus.oPeekData}, 32'hA5);
        bus.iPeekAddr = 6'h05; #1;
        check("clk5_peek", {24'd0, bus.oPeekData}, 32'h00);

        // Transaction aborted after 4 data bits must not commit.
        must_float = 1'b1;
        float_viol = 0;
        begin_tx();
        send_bits(8'h84, 8);
        send_bits(8'hFF, 4);
        end_tx();
        must_float = 1'b0;
        check("bus_float_abort", float_viol, 0);
        bus.iPeekAddr = 6'h02; #1;
        check("abort_peek", {24'd0, bus.oPeekData}, {24'd0, model_peek(1'b0, 5'd2)});
        do_write(8'h84, 8'h3C);

        // Invalid command (bit7 = 0) then extra clocks: DUT stays silent.
        must_float = 1'b1;
        float_viol = 0;
        begin_tx();
        send_bits(8'h01, 8);
        send_bits(8'($urandom), 8);
        send_bits(8'($urandom), 8);
        end_tx();
        must_float = 1'b0;
        check("bus_float_invalid", float_viol, 0);
        do_read(8'hBF);
        do_read(8'hFF);

        // Randomized mix across both banks, including unimplemented addresses.
        for (int i = 0; i < 48; i++) begin
            a = 5'($urandom_range(0, 31));
            r = 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin a = 5'($urandom_range(0, 9)); c = {2'b10, a, 1'b0}; do_write(c, r); end
                1: begin c = {2'b11, a, 1'b0}; do_write(c, r); end
                2: begin c = {2'b10, a, 1'b1}; do_read(c); end
                default: begin c = {2'b11, a, 1'b1}; do_read(c); end
            endcase
        end

        // Asynchronous reset in the middle of a read data phase.
        do_write(8'h8E, 8'h00);
        do_write(8'hC2, 8'h77);
        do_write(8'h80, 8'h33);
        begin_tx();
        send_bits(8'h81, 8);
        tick(6); sclk = 1'b1; tick(6); sclk = 1'b0;
        tick(5);
        check("oe_before_reset", {31'd0, dut.oe_q}, 1);
        rst_n = 1'b0;
        #1;
        check("oe_after_reset", {31'd0, dut.oe_q}, 0);
        check("strobe_after_reset", {31'd0, bus.oWrStrobe}, 0);
        check("wr_addr_after_reset", {26'd0, bus.oWrAddr}, 0);
        check("wr_data_after_reset", {24'd0, bus.oWrData}, 0);
        for (int i = 0; i < 8; i++)  mclk[i] = 8'h00;
        for (int i = 0; i < 31; i++) mram[i] = 8'h00;
        for (int p = 0; p < 64; p++) begin
            bus.iPeekAddr = 6'(p);
            #1;
            check("peek_after_reset", {24'd0, bus.oPeekData}, 32'h00);
        end
        nrst = 1'b0;
        sclk = 1'b0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        do_write(8'h80, 8'h44);
        do_read(8'h81);
        do_read(8'hC3);

        tick(20);
        check("wr_queue_drained", exp_wr_q.size(), 0);
        check("rd_queue_drained", exp_rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
